// File: rtl/eclk_switch_ctrl.sv
// Glitch-free edge-clock source change sequencer: stop the edge clock, flip
// the bridge-mux select, release the stop, then pulse DONE.
module eclk_switch_ctrl #(
  parameter int unsigned STOP_WAIT   = 4,
  parameter int unsigned SEL_WAIT    = 2,
  parameter int unsigned RESUME_WAIT = 3,
  parameter logic        INIT_SEL    = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic LOCK,
  input  logic SWITCH_REQ,
  input  logic SWITCH_TO,
  output logic SEL,
  output logic STOP,
  output logic BUSY,
  output logic DONE
);

  localparam int unsigned MAX_SW   = (STOP_WAIT > SEL_WAIT) ? STOP_WAIT : SEL_WAIT;
  localparam int unsigned MAX_WAIT = (MAX_SW > RESUME_WAIT) ? MAX_SW : RESUME_WAIT;
  localparam int unsigned CW       = $clog2(MAX_WAIT) + 1;

  localparam logic [CW-1:0] LD_STOP   = CW'(STOP_WAIT);
  localparam logic [CW-1:0] LD_SEL    = CW'(SEL_WAIT);
  localparam logic [CW-1:0] LD_RESUME = CW'(RESUME_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_STOP,
    HOLD_SEL,
    RESUME
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tgt_q, tgt_d;
  logic          sel_q, sel_d;
  logic          stop_q, stop_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          expired;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= INIT_SEL;
      sel_q   <= INIT_SEL;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Counter is loaded with the full wait, so a wait of N expires on its Nth cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    stop_d  = stop_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    expired = (cnt_q <= CW'(1));

    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        busy_d = 1'b0;
        if (SWITCH_REQ && LOCK) begin
          if (SWITCH_TO != sel_q) begin
            tgt_d   = SWITCH_TO;
            state_d = HOLD_STOP;
            cnt_d   = LD_STOP;
            stop_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      HOLD_STOP: begin
        if (expired) begin
          sel_d   = tgt_q;
          state_d = HOLD_SEL;
          cnt_d   = LD_SEL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD_SEL: begin
        if (expired) begin
          stop_d  = 1'b0;
          state_d = RESUME;
          cnt_d   = LD_RESUME;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESUME: begin
        if (expired) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        stop_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign SEL  = sel_q;
  assign STOP = stop_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_eclk_switch_ctrl.sv
// Bench for eclk_switch_ctrl: two instances (4/2/3 INIT_SEL=0 and 1/1/1
// INIT_SEL=1) share stimulus; a timeline model predicts outputs and DONE events.
module tb_eclk_switch_ctrl;

  localparam int S0 = 4, W0 = 2, R0 = 3;
  localparam logic I0 = 1'b0;
  localparam int S1 = 1, W1 = 1, R1 = 1;
  localparam logic I1 = 1'b1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic lock = 1'b0;
  logic req = 1'b0;
  logic to = 1'b0;
  logic sel0, stop0, busy0, done0;
  logic sel1, stop1, busy1, done1;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  typedef struct {
    int   cyc;
    logic sel;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Model state: an accepted sequence is fully described by its acceptance edge and target.
  logic act[2];
  int   seq_e[2];
  logic tgt[2];
  logic msel[2];

  eclk_switch_ctrl #(
    .STOP_WAIT(S0), .SEL_WAIT(W0), .RESUME_WAIT(R0), .INIT_SEL(I0)
  ) u_dut0 (
    .CLK(clk), .RSTN(rstn), .LOCK(lock), .SWITCH_REQ(req), .SWITCH_TO(to),
    .SEL(sel0), .STOP(stop0), .BUSY(busy0), .DONE(done0)
  );

  eclk_switch_ctrl #(
    .STOP_WAIT(S1), .SEL_WAIT(W1), .RESUME_WAIT(R1), .INIT_SEL(I1)
  ) u_dut1 (
    .CLK(clk), .RSTN(rstn), .LOCK(lock), .SWITCH_REQ(req), .SWITCH_TO(to),
    .SEL(sel1), .STOP(stop1), .BUSY(busy1), .DONE(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int p_s(input int i);
    return (i == 0) ? S0 : S1;
  endfunction
  function automatic int p_w(input int i);
    return (i == 0) ? W0 : W1;
  endfunction
  function automatic int p_t(input int i);
    return (i == 0) ? (S0 + W0 + R0) : (S1 + W1 + R1);
  endfunction
  function automatic logic p_i(input int i);
    return (i == 0) ? I0 : I1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction
  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask
  task automatic qpush(input int i, input int c, input logic s);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input string nm, input int i, input logic got, input logic exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s[%0d] cycle %0d: got %b, expected %b", nm, i, edge_n, got, exp_v);
    end
  endtask

  // Reference model: sequence accepted at edge e finishes at edge e+T, DONE visible in cycle e+T+1.
  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        act[i]  = 1'b0;
        msel[i] = p_i(i);
      end else if (act[i]) begin
        if (edge_n >= seq_e[i] + p_t(i)) begin
          act[i]  = 1'b0;
          msel[i] = tgt[i];
        end
      end else if (req && lock) begin
        if (to != msel[i]) begin
          act[i]   = 1'b1;
          seq_e[i] = edge_n;
          tgt[i]   = to;
          qpush(i, edge_n + p_t(i) + 1, to);
        end else begin
          qpush(i, edge_n + 1, msel[i]);
        end
      end
    end
    if (!rstn) begin
      q0.delete();
      q1.delete();
    end
  end

  // Per-cycle level checks of SEL/STOP/BUSY against the model timeline.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic es, et, eb;
      int   c;
      c = edge_n;
      if (!rstn) begin
        es = p_i(i); et = 1'b0; eb = 1'b0;
      end else if (act[i]) begin
        et = (c <= seq_e[i] + p_s(i) + p_w(i));
        es = (c >= seq_e[i] + p_s(i) + 1) ? tgt[i] : msel[i];
        eb = 1'b1;
      end else begin
        es = msel[i]; et = 1'b0; eb = 1'b0;
      end
      chk("SEL",  i, (i == 0) ? sel0  : sel1,  es);
      chk("STOP", i, (i == 0) ? stop0 : stop1, et);
      chk("BUSY", i, (i == 0) ? busy0 : busy1, eb);
    end
  end

  // DONE monitor: pops the scoreboard whenever a DONE pulse appears.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic d, s;
      exp_t e;
      d = (i == 0) ? done0 : done1;
      s = (i == 0) ? sel0 : sel1;
      while (qsize(i) > 0 && qfront(i).cyc < edge_n) begin
        e = qfront(i);
        n_cmp++;
        n_bad++;
        $display("FAIL DONE_missing[%0d]: no DONE seen, required at cycle %0d", i, e.cyc);
        qpop(i);
      end
      if (d === 1'b1) begin
        if (qsize(i) > 0 && qfront(i).cyc == edge_n) begin
          e = qfront(i);
          qpop(i);
          chk("DONE_SEL", i, s, e.sel);
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL DONE_unexpected[%0d] cycle %0d: got DONE=1, expected 0", i, edge_n);
        end
      end
    end
  end

  task automatic pulse_req(input logic t);
    req = 1'b1;
    to  = t;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    lock = 1'b1;
    repeat (2) @(negedge clk);

    pulse_req(1'b1);
    repeat (2) @(negedge clk);
    pulse_req(1'b0);
    repeat (8) @(negedge clk);
    pulse_req(1'b0);
    repeat (12) @(negedge clk);
    pulse_req(1'b0);
    repeat (12) @(negedge clk);

    lock = 1'b0;
    req  = 1'b1;
    to   = ~msel[0];
    repeat (20) @(negedge clk);
    lock = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (12) @(negedge clk);

    pulse_req(~msel[0]);
    repeat (5) @(negedge clk);
    mid_reset();
    repeat (15) @(negedge clk);

    req = 1'b1;
    to  = ~msel[0];
    repeat (25) @(negedge clk);
    req = 1'b0;

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        req  = ($urandom_range(0, 3) == 0);
        to   = 1'($urandom_range(0, 1));
        lock = ($urandom_range(0, 9) != 0);
        @(negedge clk);
      end
    end

    req  = 1'b0;
    lock = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) chk("DONE_drained", i, qsize(i) == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
